// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: bundles the instruction port, data port and RAM-side signals of the bus arbiter
interface mem_bus_arbiter_if;
    logic [31:0] instr_address;
    logic        instr_read;
    logic        instr_waitrequest;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_byteenable;
    logic [31:0] data_writedata;
    logic        data_waitrequest;
    logic [31:0] data_readdata;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    modport slave (
        input  instr_address, instr_read,
        output instr_waitrequest, instr_readdata,
        input  data_address, data_read, data_write, data_byteenable, data_writedata,
        output data_waitrequest, data_readdata,
        output mem_address, mem_read, mem_write, mem_byteenable, mem_writedata,
        input  mem_readdata
    );

    modport master (
        output instr_address, instr_read,
        input  instr_waitrequest, instr_readdata,
        output data_address, data_read, data_write, data_byteenable, data_writedata,
        input  data_waitrequest, data_readdata,
        input  mem_address, mem_read, mem_write, mem_byteenable, mem_writedata,
        output mem_readdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one RAM bus between instruction-fetch and data masters, one access per 3 cycles
module mem_bus_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t      state;
    logic        grant;
    logic        last_grant;
    logic [31:0] iss_address;
    logic [31:0] iss_writedata;
    logic [3:0]  iss_byteenable;
    logic        strobe_rd;
    logic        strobe_wr;
    logic        resp_instr;
    logic        resp_data;
    logic        instr_req;
    logic        data_req;
    logic        pick;
    logic        pick_wr;

    // winner selection: a lone requester wins, ties go to data or to the port not granted last
    always_comb begin
        instr_req = bus.instr_read;
        data_req  = bus.data_read | bus.data_write;
        pick      = (instr_req && data_req) ? (ROUND_ROBIN ? !last_grant : 1'b1) : data_req;
        pick_wr   = pick & bus.data_write;
    end

    // arbitration FSM; strobes and completion flags are registered so they align with the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            grant          <= 1'b0;
            last_grant     <= 1'b0;
            iss_address    <= '0;
            iss_writedata  <= '0;
            iss_byteenable <= '0;
            strobe_rd      <= 1'b0;
            strobe_wr      <= 1'b0;
            resp_instr     <= 1'b0;
            resp_data      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_instr <= 1'b0;
                    resp_data  <= 1'b0;
                    if (instr_req || data_req) begin
                        state          <= ISSUE;
                        grant          <= pick;
                        last_grant     <= pick;
                        iss_address    <= pick ? bus.data_address : bus.instr_address;
                        iss_byteenable <= pick ? bus.data_byteenable : 4'hF;
                        iss_writedata  <= pick ? bus.data_writedata : 32'h0;
                        strobe_rd      <= !pick_wr;
                        strobe_wr      <= pick_wr;
                    end
                end
                ISSUE: begin
                    state      <= RESP;
                    strobe_rd  <= 1'b0;
                    strobe_wr  <= 1'b0;
                    resp_instr <= !grant;
                    resp_data  <= grant;
                end
                default: begin
                    state      <= IDLE;
                    strobe_rd  <= 1'b0;
                    strobe_wr  <= 1'b0;
                    resp_instr <= 1'b0;
                    resp_data  <= 1'b0;
                end
            endcase
        end
    end

    // outputs are forced quiet while reset is high so an access cut by reset never reaches RAM or a master
    always_comb begin
        bus.mem_read          = strobe_rd & !reset;
        bus.mem_write         = strobe_wr & !reset;
        bus.mem_address       = (bus.mem_read | bus.mem_write) ? iss_address : 32'h0;
        bus.mem_byteenable    = (bus.mem_read | bus.mem_write) ? iss_byteenable : 4'h0;
        bus.mem_writedata     = (bus.mem_read | bus.mem_write) ? iss_writedata : 32'h0;
        bus.instr_waitrequest = instr_req & !(resp_instr & !reset);
        bus.data_waitrequest  = data_req & !(resp_data & !reset);
        bus.instr_readdata    = (resp_instr & !reset) ? bus.mem_readdata : 32'h0;
        bus.data_readdata     = (resp_data & !reset) ? bus.mem_readdata : 32'h0;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: random traffic on both arbitration modes, checked against a transaction-level model
module tb_mem_bus_arbiter;
    localparam int NCYC = 1500;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        rd;
        logic        wr;
    } txn_t;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        mem_bus_arbiter_if bus();
        mem_bus_arbiter #(.ROUND_ROBIN(g == 1)) dut (.clk(clk), .reset(reset), .bus(bus));

        logic [7:0] ram [8192];
        logic [7:0] refm [8192];
        string      p;

        // RAM: byte-lane writes, registered byte-masked read one cycle after mem_read
        always @(posedge clk) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.mem_write && bus.mem_byteenable[i])
                    ram[int'(bus.mem_address[12:2]) * 4 + i] <= bus.mem_writedata[8*i +: 8];
                if (bus.mem_read)
                    bus.mem_readdata[8*i +: 8] <= bus.mem_byteenable[i] ? ram[int'(bus.mem_address[12:2]) * 4 + i] : 8'h0;
            end
        end

        function automatic logic [31:0] ref_rd(input logic [31:0] a, input logic [3:0] be);
            logic [31:0] r;
            for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? refm[int'(a[12:2]) * 4 + i] : 8'h0;
            return r;
        endfunction

        // stimulus plus reference model: a transaction starting at cycle s strobes at s+1 and completes at s+2
        initial begin
            logic [31:0] iq[$];
            txn_t        dq[$];
            txn_t        t;
            logic        i_req, i_done, d_done, rst, ireq, dreq;
            logic [31:0] i_addr, d_addr, d_wd, rv;
            logic [3:0]  d_be;
            logic        d_rd, d_wr;
            logic        act, win, last, t_wr;
            logic [31:0] t_a, t_wd;
            logic [3:0]  t_be;
            logic        e_iw, e_dw, e_mr, e_mw;
            logic [31:0] e_ird, e_drd;
            int          s, ph;
            p = g ? "rr1" : "rr0";
            for (int i = 0; i < 8192; i++) begin
                ram[i]  = 8'h0;
                refm[i] = 8'h0;
            end
            {ram[3], ram[2], ram[1], ram[0]}     = 32'h2402000A;
            {refm[3], refm[2], refm[1], refm[0]} = 32'h2402000A;
            iq.push_back(32'hBFC00000);
            dq.push_back('{32'h00000010, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1});
            dq.push_back('{32'h00000010, 4'b0011, 32'h0, 1'b1, 1'b0});
            dq.push_back('{32'h80000000, 4'hF, 32'h12345678, 1'b1, 1'b1});
            dq.push_back('{32'h80000000, 4'hF, 32'h0, 1'b1, 1'b0});
            {i_req, i_done, d_done, d_rd, d_wr} = '0;
            {i_addr, d_addr, d_wd, d_be} = '0;
            {act, win, last, t_wr, t_a, t_wd, t_be, s} = '0;
            for (int c = 0; c < NCYC; c++) begin
                @(negedge clk);
                #1;
                if (!i_req || i_done) begin
                    if (iq.size() > 0) begin
                        i_req  = 1'b1;
                        i_addr = iq.pop_front();
                    end else begin
                        i_req  = 1'($urandom_range(0, 1));
                        i_addr = ($urandom & 32'hFFFFE000) | 32'($urandom_range(0, 31) << 2);
                    end
                end
                if (!(d_rd || d_wr) || d_done) begin
                    if (dq.size() > 0) begin
                        t = dq.pop_front();
                    end else begin
                        t.a  = ($urandom & 32'hFFFFE000) | 32'($urandom_range(0, 31) << 2);
                        t.be = 4'($urandom);
                        t.wd = $urandom;
                        case ($urandom_range(0, 5))
                            0, 1:    {t.rd, t.wr} = 2'b10;
                            2, 3:    {t.rd, t.wr} = 2'b01;
                            4:       {t.rd, t.wr} = 2'b11;
                            default: {t.rd, t.wr} = 2'b00;
                        endcase
                    end
                    {d_addr, d_be, d_wd, d_rd, d_wr} = {t.a, t.be, t.wd, t.rd, t.wr};
                end
                i_done = 1'b0;
                d_done = 1'b0;
                bus.instr_address   = i_addr;
                bus.instr_read      = i_req;
                bus.data_address    = d_addr;
                bus.data_read       = d_rd;
                bus.data_write      = d_wr;
                bus.data_byteenable = d_be;
                bus.data_writedata  = d_wd;
                #1;
                rst  = reset;
                ireq = i_req;
                dreq = d_rd | d_wr;
                ph   = act ? c - s : 0;
                e_iw = ireq;
                e_dw = dreq;
                e_mr = 1'b0;
                e_mw = 1'b0;
                e_ird = 32'h0;
                e_drd = 32'h0;
                rv = ref_rd(t_a, t_be);
                if (!rst && ph == 1) {e_mr, e_mw} = {!t_wr, t_wr};
                if (!rst && ph == 2) begin
                    if (win) e_dw = 1'b0;
                    else e_iw = 1'b0;
                    if (!win) e_ird = rv;
                    else if (!t_wr) e_drd = rv;
                end
                check({p, "_iwait"}, 32'(bus.instr_waitrequest), 32'(e_iw));
                check({p, "_dwait"}, 32'(bus.data_waitrequest), 32'(e_dw));
                check({p, "_mread"}, 32'(bus.mem_read), 32'(e_mr));
                check({p, "_mwrite"}, 32'(bus.mem_write), 32'(e_mw));
                check({p, "_irdata"}, bus.instr_readdata, e_ird);
                if (!(!rst && ph == 2 && win && t_wr)) check({p, "_drdata"}, bus.data_readdata, e_drd);
                if (rst) begin
                    check({p, "_rst_maddr"}, bus.mem_address, 32'h0);
                    check({p, "_rst_mbe"}, 32'(bus.mem_byteenable), 32'h0);
                    check({p, "_rst_mwd"}, bus.mem_writedata, 32'h0);
                end else if (ph == 1) begin
                    check({p, "_maddr"}, bus.mem_address, t_a);
                    check({p, "_mbe"}, 32'(bus.mem_byteenable), 32'(t_be));
                    if (t_wr) check({p, "_mwd"}, bus.mem_writedata, t_wd);
                end
                if (rst) begin
                    act  = 1'b0;
                    last = 1'b0;
                end else if (ph == 1) begin
                    if (t_wr)
                        for (int i = 0; i < 4; i++)
                            if (t_be[i]) refm[int'(t_a[12:2]) * 4 + i] = t_wd[8*i +: 8];
                end else if (ph == 2) begin
                    act = 1'b0;
                    if (win) d_done = 1'b1;
                    else i_done = 1'b1;
                end else if (ireq || dreq) begin
                    win  = (ireq && dreq) ? ((g == 1) ? !last : 1'b1) : dreq;
                    last = win;
                    act  = 1'b1;
                    s    = c;
                    t_a  = win ? d_addr : i_addr;
                    t_be = win ? d_be : 4'hF;
                    t_wd = win ? d_wd : 32'h0;
                    t_wr = win & d_wr;
                end
            end
        end
    end

    // reset held for the first two cycles, then pulsed at random to hit every FSM state
    initial begin
        for (int k = 0; k < NCYC + 3; k++) begin
            @(negedge clk);
            reset = (k < 2) ? 1'b1 : ($urandom_range(0, 59) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
